sid_write_scheduler: RTL and testbench
======================================

Name: sid_write_scheduler

Overview:
- Sits between the host bus and the SID register port (6-bit addr, 8-bit data, cyc/we, registered read data).
- Provides two ways to reach the SID: direct host read/write access, and a FIFO of timed register writes.
- Each queued write carries a delay in ticks; the scheduler replays the writes to the SID at those times, so the CPU can pre-load note and envelope changes.
- Direct host access always has priority over queued writes.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 4..64.
- PRESCALE, 1000, clk cycles per scheduler tick; >=2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- h_addr  in  6  direct-access register address
- h_wdata  in  8  direct-access write data
- h_cyc  in  1  direct-access request, one-cycle pulse
- h_we  in  1  direct-access write qualifier
- h_rdata  out  8  direct-access read data
- h_ack  out  1  direct-access completion pulse
- q_valid  in  1  queue push request
- q_ready  out  1  queue can accept an entry
- q_addr  in  6  queued register address
- q_data  in  8  queued write data
- q_wait  in  8  ticks to wait before issue, measured from the moment the entry becomes head
- flush  in  1  discard all queued entries and abort the pending wait
- q_level  out  $clog2(DEPTH)+1  current number of entries
- seq_busy  out  1  sequencer is not IDLE
- sid_addr  out  6  to SID addr
- sid_wdata  out  8  to SID bus_in
- sid_cyc  out  1  to SID bus_cyc
- sid_we  out  1  to SID bus_we
- sid_rdata  in  8  from SID bus_out; valid the cycle after sid_cyc

Behaviour:
- Reset values: all outputs 0 except q_ready=1. FIFO is emptied, prescaler=0, FSM=IDLE.

SID bus drive:
- sid_* are combinational from the arbiter. Exactly one requester drives the bus per cycle.
- Host h_cyc in cycle N: sid_cyc=1, sid_we=h_we, sid_addr=h_addr, sid_wdata=h_wdata, all in cycle N.
- The host gets h_ack=1 in cycle N+1, with h_rdata=sid_rdata for reads and 0 for writes.

Tick prescaler:
- Free-running counter 0..PRESCALE-1. tick=1 in the cycle the counter equals PRESCALE-1, then the counter wraps to 0.
- Not reset by flush.

FIFO:
- Entry = {addr6, data8, wait8}.
- Push when q_valid && q_ready. q_ready = level<DEPTH.
- A push and a pop in the same cycle at full are not allowed: q_ready is low at full.
- A simultaneous push and pop when not full leaves the level unchanged.
- flush empties the FIFO in one cycle. flush has priority over a same-cycle push; that push is dropped.

Sequencer FSM:
- IDLE: if FIFO not empty, pop the head into holding registers and load the wait counter with wait8.
  - wait8==0 -> ISSUE.
  - otherwise -> WAIT.
- WAIT: decrement the counter on each tick. When a tick arrives with counter==1 -> ISSUE.
- ISSUE: drive sid_cyc=1, sid_we=1 with the held addr/data if h_cyc=0 this cycle, then -> IDLE.
  - If h_cyc=1, the host wins and ISSUE holds; retry next cycle, with no limit.
- flush in any state -> IDLE next cycle; the held entry is discarded and not issued.

Timing:
- Latency with wait8=0 on an empty, idle scheduler:
  - push in cycle N, pop in cycle N+1 (IDLE sees non-empty), SID write in cycle N+2.
- Ticks seen in IDLE or ISSUE are not counted; waits are relative.
- seq_busy = FSM!=IDLE.

Decomposition:
- Package sid_sched_pkg holds:
  - SID_AW=6, SID_DW=8, WAIT_W=8.
  - Entry field offsets and ENTRY_W=22.
  - FSM state enum {IDLE, WAIT, ISSUE}.
- Sub-module sid_sched_fifo: synchronous FIFO, parameterised depth/width.
  - Ports: push, pop, flush, din, dout, level, full, empty.
  - dout shows the head combinationally.

Test Plan:
- Host write h_addr=24, h_wdata=0x0F with an idle queue -> sid_cyc=1, sid_we=1, sid_addr=24 same cycle; h_ack next cycle; h_rdata=0.
- Host read h_addr=27 while the SID returns 0x5A -> h_ack=1, h_rdata=0x5A one cycle later.
- Push {addr=4, data=0x11, wait=0} at cycle N -> single SID write addr=4 data=0x11 at N+2; q_level returns to 0.
- PRESCALE=4, push {addr=1, data=0x20, wait=3} -> write occurs in the cycle after the 3rd tick following the pop; no earlier sid_cyc.
- Fill 16 entries -> q_ready=0 and a 17th push is ignored.
  - Then flush during WAIT -> q_level=0, seq_busy=0 next cycle, no SID write.
- ISSUE coincides with host h_cyc (read addr=28) -> host access goes out first; the queued write goes out the next cycle; neither is lost.

Source files
------------

// File: rtl/sid_sched_pkg.sv
// sid_sched_pkg: shared widths, queue-entry layout and sequencer states for
// the SID write scheduler.
//   SID_AW / SID_DW  : SID register address / data widths
//   WAIT_W           : width of the per-entry tick delay
//   *_LSB, ENTRY_W   : bit layout of one queued entry {addr, data, wait}
//   sched_state_e    : sequencer FSM states
package sid_sched_pkg;

    localparam int SID_AW  = 6;
    localparam int SID_DW  = 8;
    localparam int WAIT_W  = 8;

    localparam int WAIT_LSB = 0;
    localparam int DATA_LSB = WAIT_LSB + WAIT_W;
    localparam int ADDR_LSB = DATA_LSB + SID_DW;
    localparam int ENTRY_W  = ADDR_LSB + SID_AW;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ISSUE
    } sched_state_e;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [SID_AW-1:0] addr,
        input logic [SID_DW-1:0] data,
        input logic [WAIT_W-1:0] ticks
    );
        return {addr, data, ticks};
    endfunction

endpackage

// File: rtl/sid_sched_fifo.sv
// sid_sched_fifo: synchronous FIFO with single-cycle flush.
//   clk, rst : clock, synchronous active-high reset
//   push     : write din (ignored when full or flushing)
//   pop      : advance head (ignored when empty or flushing)
//   flush    : empty the FIFO in one cycle; wins over push/pop
//   din      : entry to write
//   dout     : current head, combinational
//   level    : number of stored entries
//   full     : level == DEPTH
//   empty    : level == 0
module sid_sched_fifo
    import sid_sched_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (!do_push && do_pop) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sid_write_scheduler.sv
// sid_write_scheduler: arbitrates direct host access and a FIFO of timed
// register writes onto the SID register port. Host access always wins.
//   clk, rst            : clock, synchronous active-high reset
//   h_addr/h_wdata      : direct-access address / write data
//   h_cyc/h_we          : direct-access request pulse / write qualifier
//   h_rdata/h_ack       : read data / completion, one cycle after h_cyc
//   q_valid/q_ready     : queue push handshake
//   q_addr/q_data/q_wait: queued write and its delay in ticks (from head)
//   flush               : discard queue and any held entry
//   q_level             : entries in the queue
//   seq_busy            : sequencer holds an entry
//   sid_*               : SID register port (sid_rdata valid cycle after cyc)
module sid_write_scheduler
    import sid_sched_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int PRESCALE = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SID_AW-1:0]      h_addr,
    input  logic [SID_DW-1:0]      h_wdata,
    input  logic                   h_cyc,
    input  logic                   h_we,
    output logic [SID_DW-1:0]      h_rdata,
    output logic                   h_ack,
    input  logic                   q_valid,
    output logic                   q_ready,
    input  logic [SID_AW-1:0]      q_addr,
    input  logic [SID_DW-1:0]      q_data,
    input  logic [WAIT_W-1:0]      q_wait,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] q_level,
    output logic                   seq_busy,
    output logic [SID_AW-1:0]      sid_addr,
    output logic [SID_DW-1:0]      sid_wdata,
    output logic                   sid_cyc,
    output logic                   sid_we,
    input  logic [SID_DW-1:0]      sid_rdata
);

    localparam int PW = $clog2(PRESCALE);

    logic [PW-1:0]      ps_cnt;
    logic               tick;
    logic               ack_q;
    logic               rd_q;

    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [SID_AW-1:0]  head_addr;
    logic [SID_DW-1:0]  head_data;
    logic [WAIT_W-1:0]  head_wait;

    sched_state_e       state_q;
    sched_state_e       state_d;
    logic [SID_AW-1:0]  hold_addr;
    logic [SID_DW-1:0]  hold_data;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               load;
    logic               dec;
    logic               issue;

    // Free-running tick prescaler; deliberately untouched by flush.
    assign tick = (ps_cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    // SID read data is already registered, so h_rdata just gates it through.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            ack_q <= h_cyc;
            rd_q  <= h_cyc && !h_we;
        end
    end

    assign h_ack   = ack_q;
    assign h_rdata = rd_q ? sid_rdata : '0;

    sid_sched_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (q_valid && q_ready),
        .pop   (fifo_pop),
        .flush (flush),
        .din   (pack_entry(q_addr, q_data, q_wait)),
        .dout  (fifo_dout),
        .level (q_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign q_ready   = !fifo_full;
    assign head_addr = fifo_dout[ADDR_LSB +: SID_AW];
    assign head_data = fifo_dout[DATA_LSB +: SID_DW];
    assign head_wait = fifo_dout[WAIT_LSB +: WAIT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        load     = 1'b0;
        dec      = 1'b0;
        issue    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    load     = 1'b1;
                    state_d  = (head_wait == '0) ? ISSUE : WAIT;
                end
            end
            WAIT: begin
                if (tick) begin
                    if (wait_cnt == WAIT_W'(1)) begin
                        state_d = ISSUE;
                    end else begin
                        dec = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (!h_cyc) begin
                    issue   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d  = IDLE;
            fifo_pop = 1'b0;
            load     = 1'b0;
            dec      = 1'b0;
            issue    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_addr <= '0;
            hold_data <= '0;
            wait_cnt  <= '0;
        end else if (load) begin
            hold_addr <= head_addr;
            hold_data <= head_data;
            wait_cnt  <= head_wait;
        end else if (dec) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    assign seq_busy = (state_q != IDLE);

    always_comb begin
        sid_cyc   = 1'b0;
        sid_we    = 1'b0;
        sid_addr  = '0;
        sid_wdata = '0;
        if (h_cyc) begin
            sid_cyc   = 1'b1;
            sid_we    = h_we;
            sid_addr  = h_addr;
            sid_wdata = h_wdata;
        end else if (issue) begin
            sid_cyc   = 1'b1;
            sid_we    = 1'b1;
            sid_addr  = hold_addr;
            sid_wdata = hold_data;
        end
    end

endmodule

// File: tb/tb_sid_write_scheduler.sv
module tb_sid_write_scheduler;

    localparam int DEPTH    = 16;
    localparam int PRESCALE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] h_addr;
    logic [7:0] h_wdata;
    logic       h_cyc;
    logic       h_we;
    logic [7:0] h_rdata;
    logic       h_ack;
    logic       q_valid;
    logic       q_ready;
    logic [5:0] q_addr;
    logic [7:0] q_data;
    logic [7:0] q_wait;
    logic       flush;
    logic [4:0] q_level;
    logic       seq_busy;
    logic [5:0] sid_addr;
    logic [7:0] sid_wdata;
    logic       sid_cyc;
    logic       sid_we;
    logic [7:0] sid_rdata;

    int checks = 0;
    int errors = 0;
    int k;

    sid_write_scheduler #(
        .DEPTH    (DEPTH),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .h_cyc     (h_cyc),
        .h_we      (h_we),
        .h_rdata   (h_rdata),
        .h_ack     (h_ack),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .q_addr    (q_addr),
        .q_data    (q_data),
        .q_wait    (q_wait),
        .flush     (flush),
        .q_level   (q_level),
        .seq_busy  (seq_busy),
        .sid_addr  (sid_addr),
        .sid_wdata (sid_wdata),
        .sid_cyc   (sid_cyc),
        .sid_we    (sid_we),
        .sid_rdata (sid_rdata)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release; equals the prescaler phase origin.
    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    // Inputs change 1 time unit after the rising edge; checks happen #4 later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        h_addr = '0; h_wdata = '0; h_cyc = 1'b0; h_we = 1'b0;
        q_valid = 1'b0; q_addr = '0; q_data = '0; q_wait = '0;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        sid_rdata = '0;
        repeat (3) next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        sid_rdata = 8'hA5;
        repeat (3) next_cycle();
        #4;
        checks++; if (sid_cyc !== 1'b0) begin errors++; $display("FAIL reset_sid_cyc: got %b expected 0", sid_cyc); end
        checks++; if (sid_we !== 1'b0 || sid_addr !== 6'd0 || sid_wdata !== 8'd0) begin errors++; $display("FAIL reset_sid_bus: got we=%b addr=%0d data=%h expected 0", sid_we, sid_addr, sid_wdata); end
        checks++; if (h_ack !== 1'b0 || h_rdata !== 8'd0) begin errors++; $display("FAIL reset_host: got ack=%b rdata=%h expected 0", h_ack, h_rdata); end
        checks++; if (q_ready !== 1'b1) begin errors++; $display("FAIL reset_q_ready: got %b expected 1", q_ready); end
        checks++; if (q_level !== 5'd0 || seq_busy !== 1'b0) begin errors++; $display("FAIL reset_level_busy: got level=%0d busy=%b expected 0", q_level, seq_busy); end
        next_cycle();
        rst = 1'b0;
        sid_rdata = '0;
    endtask

    task automatic test_host_write();
        next_cycle();
        h_cyc = 1'b1; h_we = 1'b1; h_addr = 6'd24; h_wdata = 8'h0F;
        #4;
        checks++; if (sid_cyc !== 1'b1 || sid_we !== 1'b1) begin errors++; $display("FAIL hw_cyc_we: got cyc=%b we=%b expected 1 1", sid_cyc, sid_we); end
        checks++; if (sid_addr !== 6'd24 || sid_wdata !== 8'h0F) begin errors++; $display("FAIL hw_addr_data: got %0d/%h expected 24/0f", sid_addr, sid_wdata); end
        checks++; if (h_ack !== 1'b0) begin errors++; $display("FAIL hw_early_ack: got %b expected 0", h_ack); end
        next_cycle();
        idle_inputs();
        sid_rdata = 8'h99;
        #4;
        checks++; if (h_ack !== 1'b1 || h_rdata !== 8'h00) begin errors++; $display("FAIL hw_ack: got ack=%b rdata=%h expected 1 00", h_ack, h_rdata); end
        checks++; if (sid_cyc !== 1'b0) begin errors++; $display("FAIL hw_bus_release: got %b expected 0", sid_cyc); end
        next_cycle();
    endtask

    task automatic test_host_read();
        h_cyc = 1'b1; h_we = 1'b0; h_addr = 6'd27;
        #4;
        checks++; if (sid_cyc !== 1'b1 || sid_we !== 1'b0 || sid_addr !== 6'd27) begin errors++; $display("FAIL hr_bus: got cyc=%b we=%b addr=%0d expected 1 0 27", sid_cyc, sid_we, sid_addr); end
        next_cycle();
        idle_inputs();
        sid_rdata = 8'h5A;
        #4;
        checks++; if (h_ack !== 1'b1 || h_rdata !== 8'h5A) begin errors++; $display("FAIL hr_data: got ack=%b rdata=%h expected 1 5a", h_ack, h_rdata); end
        next_cycle();
        #4;
        checks++; if (h_ack !== 1'b0 || h_rdata !== 8'h00) begin errors++; $display("FAIL hr_after: got ack=%b rdata=%h expected 0 00", h_ack, h_rdata); end
        next_cycle();
        sid_rdata = '0;
    endtask

    task automatic test_queue_zero_wait();
        q_valid = 1'b1; q_addr = 6'd4; q_data = 8'h11; q_wait = 8'd0;
        #4;
        checks++; if (sid_cyc !== 1'b0) begin errors++; $display("FAIL qz_cycN: got sid_cyc=%b expected 0", sid_cyc); end
        next_cycle();
        idle_inputs();
        #4;
        checks++; if (sid_cyc !== 1'b0 || q_level !== 5'd1) begin errors++; $display("FAIL qz_cycN1: got cyc=%b level=%0d expected 0 1", sid_cyc, q_level); end
        next_cycle();
        #4;
        checks++; if (sid_cyc !== 1'b1 || sid_we !== 1'b1 || sid_addr !== 6'd4 || sid_wdata !== 8'h11) begin errors++; $display("FAIL qz_write: got cyc=%b we=%b addr=%0d data=%h expected 1 1 4 11", sid_cyc, sid_we, sid_addr, sid_wdata); end
        checks++; if (q_level !== 5'd0 || seq_busy !== 1'b1) begin errors++; $display("FAIL qz_level: got level=%0d busy=%b expected 0 1", q_level, seq_busy); end
        next_cycle();
        #4;
        checks++; if (sid_cyc !== 1'b0 || seq_busy !== 1'b0) begin errors++; $display("FAIL qz_single: got cyc=%b busy=%b expected 0 0", sid_cyc, seq_busy); end
        next_cycle();
    endtask

    task automatic test_wait_ticks(input int phase);
        int exp_k;
        int got_k;
        int c;
        int n;
        repeat (phase) next_cycle();
        q_valid = 1'b1; q_addr = 6'd1; q_data = 8'h20; q_wait = 8'd3;
        // Pop happens the cycle after the push; ticks from the following cycle on count.
        c = k + 1;
        n = 0;
        while (n < 3) begin
            c++;
            if (c % PRESCALE == PRESCALE - 1) n++;
        end
        exp_k = c + 1;
        got_k = -1;
        next_cycle();
        idle_inputs();
        for (int i = 0; i < 60; i++) begin
            #4;
            if (sid_cyc === 1'b1) begin
                got_k = k;
                break;
            end
            next_cycle();
        end
        checks++; if (got_k !== exp_k) begin errors++; $display("FAIL wait3_time: got write at cycle %0d expected %0d", got_k, exp_k); end
        checks++; if (sid_addr !== 6'd1 || sid_wdata !== 8'h20 || sid_we !== 1'b1) begin errors++; $display("FAIL wait3_data: got addr=%0d data=%h we=%b expected 1 20 1", sid_addr, sid_wdata, sid_we); end
        next_cycle();
        next_cycle();
    endtask

    task automatic test_fill_flush();
        int seen;
        q_valid = 1'b1; q_addr = 6'd2; q_data = 8'hEE; q_wait = 8'd200;
        next_cycle();
        idle_inputs();
        repeat (2) next_cycle();
        for (int i = 0; i < DEPTH; i++) begin
            q_valid = 1'b1; q_addr = 6'(i); q_data = 8'(i); q_wait = 8'd1;
            next_cycle();
        end
        q_valid = 1'b1; q_addr = 6'd63; q_data = 8'hFF;
        #4;
        checks++; if (q_level !== 5'd16 || q_ready !== 1'b0) begin errors++; $display("FAIL full_state: got level=%0d ready=%b expected 16 0", q_level, q_ready); end
        checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b expected 1", seq_busy); end
        next_cycle();
        q_valid = 1'b0;
        #4;
        checks++; if (q_level !== 5'd16) begin errors++; $display("FAIL full_drop: got level=%0d expected 16", q_level); end
        next_cycle();
        flush = 1'b1; q_valid = 1'b1;
        #4;
        checks++; if (sid_cyc !== 1'b0) begin errors++; $display("FAIL flush_bus: got %b expected 0", sid_cyc); end
        next_cycle();
        idle_inputs();
        #4;
        checks++; if (q_level !== 5'd0 || seq_busy !== 1'b0 || q_ready !== 1'b1) begin errors++; $display("FAIL flush_state: got level=%0d busy=%b ready=%b expected 0 0 1", q_level, seq_busy, q_ready); end
        seen = 0;
        for (int i = 0; i < 900; i++) begin
            next_cycle();
            #4;
            if (sid_cyc === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_write: got %0d writes expected 0", seen); end
        next_cycle();
    endtask

    task automatic test_collision();
        q_valid = 1'b1; q_addr = 6'd9; q_data = 8'h77; q_wait = 8'd0;
        next_cycle();
        idle_inputs();
        next_cycle();
        h_cyc = 1'b1; h_we = 1'b0; h_addr = 6'd28;
        #4;
        checks++; if (sid_cyc !== 1'b1 || sid_we !== 1'b0 || sid_addr !== 6'd28) begin errors++; $display("FAIL col_host: got cyc=%b we=%b addr=%0d expected 1 0 28", sid_cyc, sid_we, sid_addr); end
        checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL col_hold: got busy=%b expected 1", seq_busy); end
        next_cycle();
        idle_inputs();
        sid_rdata = 8'hC3;
        #4;
        checks++; if (sid_cyc !== 1'b1 || sid_we !== 1'b1 || sid_addr !== 6'd9 || sid_wdata !== 8'h77) begin errors++; $display("FAIL col_queued: got cyc=%b we=%b addr=%0d data=%h expected 1 1 9 77", sid_cyc, sid_we, sid_addr, sid_wdata); end
        checks++; if (h_ack !== 1'b1 || h_rdata !== 8'hC3) begin errors++; $display("FAIL col_rdata: got ack=%b rdata=%h expected 1 c3", h_ack, h_rdata); end
        next_cycle();
        #4;
        checks++; if (sid_cyc !== 1'b0 || seq_busy !== 1'b0) begin errors++; $display("FAIL col_done: got cyc=%b busy=%b expected 0 0", sid_cyc, seq_busy); end
        next_cycle();
        sid_rdata = '0;
    endtask

    typedef struct packed {
        logic [5:0] a;
        logic [7:0] d;
        logic [7:0] w;
    } ent_t;

    // Reference: a queue of entries plus at most one held entry with its
    // remaining tick count; it may go out once no ticks remain and the host
    // is silent.
    task automatic test_random(input int cycles);
        ent_t mq[$];
        ent_t held;
        ent_t e;
        bit   held_v;
        int   left;
        bit   prev_cyc;
        bit   prev_rd;
        bit   tick_m;
        bit   e_cyc;
        bit   e_we;
        logic [5:0] e_addr;
        logic [7:0] e_data;
        int   old_size;
        do_reset();
        held_v = 0; left = 0; prev_cyc = 0; prev_rd = 0; held = '0;
        for (int i = 0; i < cycles; i++) begin
            h_cyc   = ($urandom_range(0, 4) == 0);
            h_we    = 1'($urandom);
            h_addr  = 6'($urandom);
            h_wdata = 8'($urandom);
            q_valid = 1'($urandom);
            q_addr  = 6'($urandom);
            q_data  = 8'($urandom);
            q_wait  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
            flush   = ($urandom_range(0, 79) == 0);
            sid_rdata = 8'($urandom);
            #4;
            tick_m = (k % PRESCALE) == PRESCALE - 1;
            e_cyc = 0; e_we = 0; e_addr = '0; e_data = '0;
            if (h_cyc) begin
                e_cyc = 1; e_we = h_we; e_addr = h_addr; e_data = h_wdata;
            end else if (held_v && left == 0 && !flush) begin
                e_cyc = 1; e_we = 1; e_addr = held.a; e_data = held.d;
            end
            checks++; if (sid_cyc !== e_cyc) begin errors++; $display("FAIL rnd_cyc @%0d: got %b expected %b", k, sid_cyc, e_cyc); end
            if (e_cyc) begin
                checks++; if (sid_we !== e_we || sid_addr !== e_addr || sid_wdata !== e_data) begin errors++; $display("FAIL rnd_bus @%0d: got we=%b addr=%0d data=%h expected %b %0d %h", k, sid_we, sid_addr, sid_wdata, e_we, e_addr, e_data); end
            end
            checks++; if (q_level !== 5'(mq.size()) || q_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_level @%0d: got level=%0d ready=%b expected %0d", k, q_level, q_ready, mq.size()); end
            checks++; if (seq_busy !== held_v) begin errors++; $display("FAIL rnd_busy @%0d: got %b expected %b", k, seq_busy, held_v); end
            checks++; if (h_ack !== prev_cyc || h_rdata !== (prev_rd ? sid_rdata : 8'h00)) begin errors++; $display("FAIL rnd_host @%0d: got ack=%b rdata=%h expected %b %h", k, h_ack, h_rdata, prev_cyc, prev_rd ? sid_rdata : 8'h00); end
            old_size = mq.size();
            prev_cyc = h_cyc;
            prev_rd  = h_cyc && !h_we;
            if (flush) begin
                mq.delete();
                held_v = 0;
            end else begin
                if (held_v) begin
                    if (left == 0) begin
                        if (!h_cyc) held_v = 0;
                    end else if (tick_m) begin
                        left--;
                    end
                end else if (mq.size() > 0) begin
                    held   = mq.pop_front();
                    left   = int'(held.w);
                    held_v = 1;
                end
                if (q_valid && old_size < DEPTH) begin
                    e.a = q_addr; e.d = q_data; e.w = q_wait;
                    mq.push_back(e);
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        sid_rdata = '0;
        rst = 1'b1;
        #1;
        test_reset();
        test_host_write();
        test_host_read();
        test_queue_zero_wait();
        test_wait_ticks(0);
        test_wait_ticks(1);
        test_wait_ticks(2);
        test_wait_ticks(3);
        test_fill_flush();
        test_collision();
        test_random(4000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
